bcp_engine_param: RTL
=====================

Name: bcp_engine_param

Overview:
- Parametrised Boolean-constraint-propagation engine for the SAT accelerator; successor to the fixed-size BCP unit.
- Holds a clause store of NUM_CLAUSES clauses, each with up to LITS_PER_CLAUSE literals, plus the variable assignment/free state.
- Scans clauses sequentially until no new implication is found, detecting unit clauses and conflicts.
- Keeps an assignment trail so the controller can backtrack to any trail position.

Parameters:
- NUM_VARS, 64, number of variables.
- NUM_CLAUSES, 32, clause store depth.
- LITS_PER_CLAUSE, 3, literal slots per clause.
- VAR_W, $clog2(NUM_VARS), variable index width.
- CL_W, $clog2(NUM_CLAUSES), clause index width.
- LIT_W, VAR_W+2, literal encoding {valid, neg, var}.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cl_wr_en  in  1  write one clause.
- cl_wr_addr  in  CL_W  clause index.
- cl_wr_data  in  LITS_PER_CLAUSE*LIT_W  literals; slot 0 in the LSBs.
- cl_wr_valid  in  1  clause-valid bit stored with the clause.
- decide_en  in  1  decision assignment.
- decide_var  in  VAR_W  decided variable.
- decide_val  in  1  decided value.
- start  in  1  begin propagation.
- bt_en  in  1  backtrack request.
- bt_pos  in  VAR_W+1  target trail length.
- busy  out  1  high in SCAN or UNDO.
- done  out  1  one-cycle pulse at fixed point, no conflict.
- conflict  out  1  sticky conflict flag.
- conflict_clause  out  CL_W  index of the falsified clause.
- decide_err  out  1  one-cycle pulse: decision rejected.
- trail_len  out  VAR_W+1  assigned-variable count.
- imp_count  out  VAR_W+1  implications made since last start.
- assignment  out  NUM_VARS  variable values.
- free  out  NUM_VARS  1 = unassigned.

Behaviour:
- Reset values:
  - assignment=0, free=all 1s.
  - trail_len=0, imp_count=0, conflict=0, conflict_clause=0.
  - busy=0, done=0, decide_err=0.
  - All clause-valid bits cleared; state IDLE.
- States:
  - IDLE, SCAN, DONE, CONF, UNDO.
  - DONE and CONF hold until the next command. Commands are accepted only in IDLE, DONE and CONF.
- Clause write:
  - Accepted in any non-busy state; takes effect next cycle.
  - Ignored while busy.
- Decision:
  - If free[decide_var]=1: assignment[var]<=decide_val, free[var]<=0, trail[trail_len]<=var, trail_len+1.
  - If var is already assigned or busy=1: no state change, decide_err pulses next cycle.
- Literal evaluation:
  - A literal is ignored when its valid bit is 0.
  - The literal is true when its var is assigned and assignment[var]^neg=1.
  - The literal is false when its var is assigned and assignment[var]^neg=0.
- start:
  - Clears conflict and imp_count, sets clause pointer=0 and changed=0.
  - Enters SCAN next cycle.
- SCAN, one clause per cycle (index = pointer):
  - Invalid clause, or any literal true: skip.
  - No true literal and zero unassigned literals: conflict<=1, conflict_clause<=pointer, go to CONF.
  - Exactly one unassigned literal: assign its var the value making it true (value=~neg), push it on the trail, imp_count+1, changed<=1.
  - The assignment is visible to the evaluation of the next clause in the following cycle.
  - Two or more unassigned literals: skip.
  - Pointer wrap at NUM_CLAUSES-1:
    - changed=1: pointer<=0, changed<=0, continue SCAN.
    - Otherwise: pulse done and enter DONE.
- Latency: an empty pass takes NUM_CLAUSES cycles from the first SCAN cycle to the done pulse.
- Duplicate literal of the same var within one clause is counted once per slot. Software guarantees no duplicates; no checking is required.
- Backtrack (bt_en):
  - bt_pos>=trail_len: no-op, stay in the current state.
  - Otherwise enter UNDO. Each cycle pop one entry: free[trail[trail_len-1]]<=1, trail_len-1.
  - When trail_len==bt_pos, go to IDLE and clear conflict.
  - Assignment bits of freed vars are left unchanged; they are don't-care.
- Simultaneous commands, priority bt_en > decide_en > start:
  - bt_en with anything else: only the backtrack executes.
  - decide_en with start: the decision is applied this cycle and SCAN begins next cycle including it.
  - Rejected decide with start: decide_err pulses and start still proceeds.
- Trail cannot overflow: at most NUM_VARS entries, one per variable.
- rst mid-SCAN or mid-UNDO: full reset to the reset values; clause store validity is lost.

Test Plan:
- Bench config NUM_VARS=8, NUM_CLAUSES=4, LITS_PER_CLAUSE=3 for all scenarios.
- Reset, then start with no clauses -> done pulses after 4 SCAN cycles, trail_len=0, free=8'hFF.
- Clause0=(x0 ∨ x1), decide x0=0, start -> x1 assigned 1, imp_count=1, trail_len=2, done, conflict=0.
- Clause0=(¬x0 ∨ x1), clause1=(¬x1 ∨ x2), decide x0=1, start -> x1=1 and x2=1 in pass 1, second pass finds nothing, done after 8 SCAN cycles, imp_count=2.
- Clause2=(¬x0 ∨ ¬x1), clause3=(¬x0 ∨ x1), decide x0=1, start -> x1 implied 0 at clause2, clause3 falsified -> conflict=1, conflict_clause=3.
- From the conflict case (trail_len=2), bt_en with bt_pos=0 -> UNDO for 2 cycles, free=8'hFF, trail_len=0, conflict=0, state IDLE.
- Decide x3 twice -> second attempt pulses decide_err, trail_len stays 1. start+bt_en in the same cycle -> backtrack only, no SCAN.

Source files
------------

// File: rtl/bcp_engine_param.sv
// bcp_engine_param: parametrised Boolean-constraint-propagation engine with clause store and backtrack trail.
// Ports: clause write (cl_wr_*), decisions (decide_*), start, backtrack (bt_*);
// status busy/done/conflict/decide_err, trail_len, imp_count, assignment and free vectors.
module bcp_engine_param #(
  parameter int NUM_VARS = 64,
  parameter int NUM_CLAUSES = 32,
  parameter int LITS_PER_CLAUSE = 3,
  parameter int VAR_W = $clog2(NUM_VARS),
  parameter int CL_W = $clog2(NUM_CLAUSES),
  parameter int LIT_W = VAR_W + 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cl_wr_en_i,
  input  logic [CL_W-1:0] cl_wr_addr_i,
  input  logic [LITS_PER_CLAUSE*LIT_W-1:0] cl_wr_data_i,
  input  logic cl_wr_valid_i,
  input  logic decide_en_i,
  input  logic [VAR_W-1:0] decide_var_i,
  input  logic decide_val_i,
  input  logic start_i,
  input  logic bt_en_i,
  input  logic [VAR_W:0] bt_pos_i,
  output logic busy_o,
  output logic done_o,
  output logic conflict_o,
  output logic [CL_W-1:0] conflict_clause_o,
  output logic decide_err_o,
  output logic [VAR_W:0] trail_len_o,
  output logic [VAR_W:0] imp_count_o,
  output logic [NUM_VARS-1:0] assignment_o,
  output logic [NUM_VARS-1:0] free_o
);
  localparam int NF_W = $clog2(LITS_PER_CLAUSE + 1);
  localparam logic [CL_W-1:0] LAST = CL_W'(NUM_CLAUSES - 1);
  typedef enum logic [2:0] {IDLE, SCAN, DONE, CONF, UNDO} state_e;
  state_e state_q, state_d;
  logic [LITS_PER_CLAUSE*LIT_W-1:0] cl_q [NUM_CLAUSES];
  logic [NUM_CLAUSES-1:0] cl_valid_q;
  logic [VAR_W-1:0] trail_q [NUM_VARS];
  logic [NUM_VARS-1:0] assign_q, assign_d, free_q, free_d;
  logic [VAR_W:0] len_q, len_d, imp_q, imp_d, bt_q, bt_d;
  logic [CL_W-1:0] ptr_q, ptr_d, conf_cl_q, conf_cl_d;
  logic changed_q, changed_d, conf_q, conf_d, done_q, done_d, derr_q, derr_d;
  logic busy, any_true, imp, tr_we, unit_val;
  logic [NF_W-1:0] n_free;
  logic [LIT_W-1:0] lit;
  logic [VAR_W-1:0] unit_var, tr_var, tr_top;
  assign busy = state_q == SCAN || state_q == UNDO;
  assign tr_top = trail_q[VAR_W'(len_q - 1'b1)];
  // classify the clause under the pointer: any true literal, count of unassigned literals
  always_comb begin
    any_true = 1'b0;
    n_free = '0;
    unit_var = '0;
    unit_val = 1'b0;
    lit = '0;
    for (int s = 0; s < LITS_PER_CLAUSE; s++) begin
      lit = cl_q[ptr_q][s*LIT_W +: LIT_W];
      if (lit[LIT_W-1]) begin
        if (free_q[lit[VAR_W-1:0]]) begin
          n_free = n_free + 1'b1;
          unit_var = lit[VAR_W-1:0];
          unit_val = ~lit[VAR_W];
        end else if (assign_q[lit[VAR_W-1:0]] ^ lit[VAR_W]) any_true = 1'b1;
      end
    end
    imp = state_q == SCAN && cl_valid_q[ptr_q] && !any_true && n_free == NF_W'(1);
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    changed_d = changed_q;
    assign_d = assign_q;
    free_d = free_q;
    len_d = len_q;
    imp_d = imp_q;
    conf_d = conf_q;
    conf_cl_d = conf_cl_q;
    bt_d = bt_q;
    done_d = 1'b0;
    derr_d = 1'b0;
    tr_we = 1'b0;
    tr_var = '0;
    if (busy) begin
      derr_d = decide_en_i;
      if (state_q == SCAN) begin
        if (cl_valid_q[ptr_q] && !any_true && n_free == '0) begin
          conf_d = 1'b1;
          conf_cl_d = ptr_q;
          state_d = CONF;
        end else begin
          if (imp) begin
            assign_d[unit_var] = unit_val;
            free_d[unit_var] = 1'b0;
            tr_we = 1'b1;
            tr_var = unit_var;
            len_d = len_q + 1'b1;
            imp_d = imp_q + 1'b1;
          end
          // an implication on the last clause still forces another pass
          ptr_d = ptr_q == LAST ? '0 : ptr_q + 1'b1;
          changed_d = ptr_q == LAST ? 1'b0 : changed_q || imp;
          if (ptr_q == LAST && !(changed_q || imp)) begin
            done_d = 1'b1;
            state_d = DONE;
          end
        end
      end else begin
        free_d[tr_top] = 1'b1;
        len_d = len_q - 1'b1;
        if (len_d == bt_q) begin
          state_d = IDLE;
          conf_d = 1'b0;
        end
      end
    end else if (bt_en_i) begin
      if (bt_pos_i < len_q) begin
        state_d = UNDO;
        bt_d = bt_pos_i;
      end
    end else begin
      if (decide_en_i) begin
        if (free_q[decide_var_i]) begin
          assign_d[decide_var_i] = decide_val_i;
          free_d[decide_var_i] = 1'b0;
          tr_we = 1'b1;
          tr_var = decide_var_i;
          len_d = len_q + 1'b1;
        end else derr_d = 1'b1;
      end
      if (start_i) begin
        conf_d = 1'b0;
        imp_d = '0;
        ptr_d = '0;
        changed_d = 1'b0;
        state_d = SCAN;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      changed_q <= 1'b0;
      assign_q <= '0;
      free_q <= '1;
      len_q <= '0;
      imp_q <= '0;
      conf_q <= 1'b0;
      conf_cl_q <= '0;
      bt_q <= '0;
      done_q <= 1'b0;
      derr_q <= 1'b0;
      cl_valid_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      changed_q <= changed_d;
      assign_q <= assign_d;
      free_q <= free_d;
      len_q <= len_d;
      imp_q <= imp_d;
      conf_q <= conf_d;
      conf_cl_q <= conf_cl_d;
      bt_q <= bt_d;
      done_q <= done_d;
      derr_q <= derr_d;
      if (cl_wr_en_i && !busy) cl_valid_q[cl_wr_addr_i] <= cl_wr_valid_i;
    end
  end
  always_ff @(posedge clk) begin
    if (cl_wr_en_i && !busy) cl_q[cl_wr_addr_i] <= cl_wr_data_i;
    if (tr_we) trail_q[VAR_W'(len_q)] <= tr_var;
  end
  assign busy_o = busy;
  assign done_o = done_q;
  assign conflict_o = conf_q;
  assign conflict_clause_o = conf_cl_q;
  assign decide_err_o = derr_q;
  assign trail_len_o = len_q;
  assign imp_count_o = imp_q;
  assign assignment_o = assign_q;
  assign free_o = free_q;
endmodule
